// File: rtl/bitcoin_pkg.sv
// Shared definitions for the nonce hasher and the hash result scanner:
// the nonce count default, the scanner state encoding and the layout of
// the two-word result record.
package bitcoin_pkg;

   // Number of nonces hashed and scanned per job.
   localparam int NUM_NONCES = 16;

   // Result record layout: word 0 = {found, zeros, nonce}, word 1 = best hash.
   localparam int RESULT_FOUND_BIT = 31;
   localparam int RESULT_LEN       = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_SCAN  = 3'd2,
      S_WR0   = 3'd3,
      S_WR1   = 3'd4,
      S_FIN   = 3'd5
   } scan_state_t;

   // Builds record word 0. The nonce index is at most 8 bits wide
   // (NUM_NONCES <= 256), so callers zero-extend it to 8 bits.
   function automatic logic [31:0] make_result_word0(input logic found_bit,
                                                     input logic [7:0] nonce);
      logic [31:0] word;
      word = '0;
      word[RESULT_FOUND_BIT] = found_bit;
      word[7:0] = nonce;
      return word;
   endfunction

endpackage

// File: rtl/hash_result_scanner_min_tracker.sv
// Registered compare-and-keep: holds the smallest value seen since the last
// clear together with the index it arrived with. Updates only on a strictly
// smaller value, so among equal values the first one offered is kept.
module min_tracker #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [31:0]      value,
   input  logic [IDX_W-1:0] idx,
   output logic [31:0]      min_value,
   output logic [IDX_W-1:0] min_idx
);

   logic [31:0]      min_value_reg;
   logic [IDX_W-1:0] min_idx_reg;

   // Clear loads the worst possible value; enabled samples replace it only if smaller.
   always_ff @(posedge clk) begin
      if (reset) begin
         min_value_reg <= '0;
         min_idx_reg   <= '0;
      end else if (clear) begin
         min_value_reg <= 32'hFFFF_FFFF;
         min_idx_reg   <= '0;
      end else if (en && (value < min_value_reg)) begin
         min_value_reg <= value;
         min_idx_reg   <= idx;
      end
   end

   assign min_value = min_value_reg;
   assign min_idx   = min_idx_reg;

endmodule

// File: rtl/hash_result_scanner.sv
// Reads back one H0 word per nonce from the shared memory, keeps the
// minimum and its nonce index, compares it against the difficulty target,
// writes a two-word result record and pulses done.
module hash_result_scanner
   import bitcoin_pkg::*;
#(
   parameter int NUM_NONCES = bitcoin_pkg::NUM_NONCES,
   parameter int NONCE_W    = $clog2(NUM_NONCES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [15:0]        input_addr,
   input  logic [15:0]        result_addr,
   input  logic [31:0]        target,
   output logic               done,
   output logic               found,
   output logic [NONCE_W-1:0] best_nonce,
   output logic [31:0]        best_hash,
   output logic               mem_clk,
   output logic               mem_we,
   output logic [15:0]        mem_addr,
   output logic [31:0]        mem_write_data,
   input  logic [31:0]        mem_read_data
);

   // Read counter runs 1..NUM_NONCES, so it needs one bit more than the index.
   localparam logic [NONCE_W:0]   RD_END = (NONCE_W+1)'(NUM_NONCES);
   localparam logic [NONCE_W-1:0] K_LAST = NONCE_W'(NUM_NONCES - 1);

   scan_state_t        state_reg, state_next;
   logic [NONCE_W:0]   rd_cnt_reg, rd_cnt_next;
   logic [NONCE_W-1:0] k_reg, k_next;
   logic [15:0]        mem_addr_reg, mem_addr_next;
   logic               mem_we_reg, mem_we_next;
   logic [31:0]        wdata_reg, wdata_next;
   logic               done_reg, done_next;
   logic               found_reg, found_next;
   logic               track_clear;
   logic               track_en;
   logic               below_target;

   // The memory runs on the scanner clock.
   assign mem_clk = clk;

   // best_hash is final by the time WR0 uses this.
   assign below_target = (best_hash < target);

   min_tracker #(
      .IDX_W (NONCE_W)
   ) u_min_tracker (
      .clk       (clk),
      .reset     (reset),
      .clear     (track_clear),
      .en        (track_en),
      .value     (mem_read_data),
      .idx       (k_reg),
      .min_value (best_hash),
      .min_idx   (best_nonce)
   );

   // State and output registers; reset wins in every state and abandons any record.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         rd_cnt_reg   <= '0;
         k_reg        <= '0;
         mem_addr_reg <= '0;
         mem_we_reg   <= 1'b0;
         wdata_reg    <= '0;
         done_reg     <= 1'b0;
         found_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rd_cnt_reg   <= rd_cnt_next;
         k_reg        <= k_next;
         mem_addr_reg <= mem_addr_next;
         mem_we_reg   <= mem_we_next;
         wdata_reg    <= wdata_next;
         done_reg     <= done_next;
         found_reg    <= found_next;
      end
   end

   // Next-state and next-output logic for the scan sequence.
   always_comb begin
      state_next    = state_reg;
      rd_cnt_next   = rd_cnt_reg;
      k_next        = k_reg;
      mem_addr_next = mem_addr_reg;
      mem_we_next   = mem_we_reg;
      wdata_next    = wdata_reg;
      done_next     = 1'b0;
      found_next    = found_reg;
      track_clear   = 1'b0;
      track_en      = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               mem_addr_next = input_addr;
               rd_cnt_next   = (NONCE_W+1)'(1);
               k_next        = '0;
               mem_we_next   = 1'b0;
               track_clear   = 1'b1;
               state_next    = S_PRIME;
            end
         end

         // Second read address goes out while the first word is in the RAM register.
         S_PRIME: begin
            mem_addr_next = input_addr + 16'(rd_cnt_reg);
            rd_cnt_next   = rd_cnt_reg + (NONCE_W+1)'(1);
            state_next    = S_SCAN;
         end

         // One word arrives per cycle; keep the read address one ahead of capture.
         S_SCAN: begin
            track_en = 1'b1;
            k_next   = k_reg + NONCE_W'(1);
            if (rd_cnt_reg < RD_END) begin
               mem_addr_next = input_addr + 16'(rd_cnt_reg);
               rd_cnt_next   = rd_cnt_reg + (NONCE_W+1)'(1);
            end
            if (k_reg == K_LAST) begin
               state_next = S_WR0;
            end
         end

         S_WR0: begin
            mem_we_next   = 1'b1;
            mem_addr_next = result_addr;
            wdata_next    = make_result_word0(below_target, 8'(best_nonce));
            found_next    = below_target;
            state_next    = S_WR1;
         end

         S_WR1: begin
            mem_addr_next = result_addr + 16'd1;
            wdata_next    = best_hash;
            state_next    = S_FIN;
         end

         S_FIN: begin
            mem_we_next = 1'b0;
            done_next   = 1'b1;
            state_next  = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign done           = done_reg;
   assign found          = found_reg;
   assign mem_we         = mem_we_reg;
   assign mem_addr       = mem_addr_reg;
   assign mem_write_data = wdata_reg;

endmodule

// File: tb/tb_hash_result_scanner.sv
// Self-checking bench for hash_result_scanner with a behavioural RAM model,
// directed table vectors, randomized scans and multi-cycle corner sequences.
module tb_hash_result_scanner;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] input_addr;
   logic [15:0] result_addr;
   logic [31:0] target;
   logic        done;
   logic        found;
   logic [3:0]  best_nonce;
   logic [31:0] best_hash;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [31:0] mem [0:65535];
   logic [15:0] wr_addr_q [$];
   logic [15:0] rd_addr_q [$];
   logic [31:0] words [N];

   typedef struct {
      string       name;
      logic [15:0] ia;
      logic [15:0] ra;
      logic [31:0] tg;
      int          pat;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        ef;
      logic [3:0]  en;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   hash_result_scanner #(.NUM_NONCES(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .input_addr     (input_addr),
      .result_addr    (result_addr),
      .target         (target),
      .done           (done),
      .found          (found),
      .best_nonce     (best_nonce),
      .best_hash      (best_hash),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Synchronous RAM plus a log of write and read addresses.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) begin
         mem[mem_addr] <= mem_write_data;
         wr_addr_q.push_back(mem_addr);
      end else begin
         rd_addr_q.push_back(mem_addr);
      end
      mem_read_data <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   // Fills the N words starting at ia according to a pattern and mirrors them in words[].
   task automatic fill(input logic [15:0] ia, input int pat);
      logic [15:0] a;
      for (int i = 0; i < N; i++) begin
         case (pat)
            0: words[i] = (i == 5) ? 32'h0000_1234 : 32'h8000_0000 + 32'(i);
            1: words[i] = 32'hFFFF_FFF0;
            2: words[i] = (i == 3 || i == 9) ? 32'h10 : 32'h100 + 32'(i);
            4: words[i] = (i == 12) ? 32'h42 : 32'h4000_0000 + 32'(i);
            default: words[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
         endcase
         a = ia + 16'(i);
         mem[a] = words[i];
      end
   endtask

   // Starts a scan and counts edges from the start edge until done is seen.
   // busy_at >= 0 re-asserts start for one cycle during the scan.
   task automatic run_scan(input logic [15:0] ia, input logic [15:0] ra, input logic [31:0] tg,
                           input int busy_at, output int lat);
      @(negedge clk);
      input_addr  = ia;
      result_addr = ra;
      target      = tg;
      mem[ra]     = 32'hDEAD_BEEF;
      mem[ra + 16'd1] = 32'hDEAD_BEEF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_addr_q.delete();
      rd_addr_q.delete();
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         start = (lat == busy_at) ? 1'b1 : 1'b0;
         if (done) break;
      end
      start = 1'b0;
      chk("done_seen", 32'(done), 32'd1);
   endtask

   task automatic check_result(input string nm, input logic [15:0] ra, input int lat,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic ef, input logic [3:0] en);
      chk({nm, "_lat"}, 32'(lat), 32'(N + 4));
      chk({nm, "_rec0"}, mem[ra], e0);
      chk({nm, "_rec1"}, mem[ra + 16'd1], e1);
      chk({nm, "_found"}, 32'(found), 32'(ef));
      chk({nm, "_nonce"}, 32'(best_nonce), 32'(en));
      chk({nm, "_hash"}, best_hash, e1);
      chk({nm, "_nwrites"}, 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() == 2) begin
         chk({nm, "_waddr0"}, 32'(wr_addr_q[0]), 32'(ra));
         chk({nm, "_waddr1"}, 32'(wr_addr_q[1]), 32'(ra + 16'd1));
      end
      $display("scan %s: rec0=%h rec1=%h found=%0d nonce=%0d lat=%0d",
               nm, mem[ra], mem[ra + 16'd1], found, best_nonce, lat);
   endtask

   initial begin
      int          lat;
      int          hits;
      int          strays;
      int          dn;
      int          done_cyc [$];
      logic [31:0] mn;
      logic [3:0]  mi;
      logic [15:0] ia;
      logic [15:0] ra;
      logic [31:0] tg;
      logic [15:0] a;
      logic        ef;

      vecs[0] = '{"single_min", 16'h0010, 16'h0200, 32'h0001_0000, 0, 32'h8000_0005, 32'h0000_1234, 1'b1, 4'd5};
      vecs[1] = '{"none_below", 16'h0040, 16'h0300, 32'h0000_0100, 1, 32'h0000_0000, 32'hFFFF_FFF0, 1'b0, 4'd0};
      vecs[2] = '{"tie",        16'h0080, 16'h0400, 32'h0000_0010, 2, 32'h0000_0003, 32'h0000_0010, 1'b0, 4'd3};
      vecs[3] = '{"wrap",       16'hFFF8, 16'h0100, 32'h0000_0100, 4, 32'h8000_000C, 32'h0000_0042, 1'b1, 4'd12};

      reset = 1'b1;
      start = 1'b0;
      input_addr  = '0;
      result_addr = '0;
      target      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_done", 32'(done), 32'd0);
      chk("rst_found", 32'(found), 32'd0);
      chk("rst_nonce", 32'(best_nonce), 32'd0);
      chk("rst_hash", best_hash, 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_write_data, 32'd0);

      // Directed table vectors.
      for (int v = 0; v < 4; v++) begin
         fill(vecs[v].ia, vecs[v].pat);
         run_scan(vecs[v].ia, vecs[v].ra, vecs[v].tg, -1, lat);
         check_result(vecs[v].name, vecs[v].ra, lat, vecs[v].e0, vecs[v].e1, vecs[v].ef, vecs[v].en);
      end

      // Wrap scan must have read FFF8..FFFF then 0000..0007 and nothing just outside.
      hits = 0;
      for (int i = 0; i < N; i++) begin
         a = 16'hFFF8 + 16'(i);
         foreach (rd_addr_q[j]) begin
            if (rd_addr_q[j] == a) begin
               hits++;
               break;
            end
         end
      end
      strays = 0;
      foreach (rd_addr_q[j]) begin
         if (rd_addr_q[j] == 16'h0008 || rd_addr_q[j] == 16'hFFF7) strays++;
      end
      chk("wrap_reads_hit", 32'(hits), 32'(N));
      chk("wrap_reads_stray", 32'(strays), 32'd0);

      // Randomized scans against the reference: minimum value, first index holding it.
      for (int r = 0; r < 8; r++) begin
         ia = 16'($urandom);
         ra = ia + 16'h1000;
         fill(ia, 3);
         mn = words[0];
         foreach (words[i]) if (words[i] < mn) mn = words[i];
         mi = 4'd0;
         for (int i = N - 1; i >= 0; i--) if (words[i] == mn) mi = 4'(i);
         case (r % 3)
            0: tg = mn;
            1: tg = mn + 32'd1;
            default: tg = $urandom;
         endcase
         ef = (mn < tg);
         run_scan(ia, ra, tg, -1, lat);
         check_result($sformatf("rand%0d", r), ra, lat, {ef, 27'd0, mi}, mn, ef, mi);
      end

      // Reset sampled at E8 abandons the scan: no writes, no done, reset values.
      fill(16'h0500, 0);
      @(negedge clk);
      input_addr  = 16'h0500;
      result_addr = 16'h0600;
      target      = 32'h0001_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_addr_q.delete();
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_found", 32'(found), 32'd0);
      chk("mrst_nonce", 32'(best_nonce), 32'd0);
      chk("mrst_hash", best_hash, 32'd0);
      chk("mrst_we", 32'(mem_we), 32'd0);
      chk("mrst_addr", 32'(mem_addr), 32'd0);
      chk("mrst_wdata", mem_write_data, 32'd0);
      dn = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      chk("mrst_no_done", 32'(dn), 32'd0);
      chk("mrst_no_write", 32'(wr_addr_q.size()), 32'd0);
      $display("scan reset_mid: abandoned, writes=%0d dones=%0d", wr_addr_q.size(), dn);
      run_scan(16'h0500, 16'h0600, 32'h0001_0000, -1, lat);
      check_result("after_reset", 16'h0600, lat, 32'h8000_0005, 32'h0000_1234, 1'b1, 4'd5);

      // start pulsed during SCAN is ignored: same timing, one record, no follow-on scan.
      fill(16'h0700, 2);
      run_scan(16'h0700, 16'h0800, 32'h0000_0011, 5, lat);
      check_result("busy_start", 16'h0800, lat, 32'h8000_0003, 32'h0000_0010, 1'b1, 4'd3);
      wr_addr_q.delete();
      dn = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      chk("busy_no_rescan_done", 32'(dn), 32'd0);
      chk("busy_no_rescan_write", 32'(wr_addr_q.size()), 32'd0);

      // start held high: back-to-back scans with done every N+5 cycles.
      fill(16'h0900, 0);
      @(negedge clk);
      input_addr  = 16'h0900;
      result_addr = 16'h0A00;
      target      = 32'h0001_0000;
      start = 1'b1;
      for (int c = 0; c < 120 && done_cyc.size() < 3; c++) begin
         @(posedge clk);
         #1;
         if (done) done_cyc.push_back(cyc);
      end
      start = 1'b0;
      chk("b2b_ndone", 32'(done_cyc.size()), 32'd3);
      if (done_cyc.size() == 3) begin
         chk("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'(N + 5));
         chk("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'(N + 5));
      end
      repeat (30) @(posedge clk);
      #1;
      chk("b2b_rec0", mem[16'h0A00], 32'h8000_0005);
      chk("b2b_rec1", mem[16'h0A01], 32'h0000_1234);
      $display("scan back_to_back: dones=%0d", done_cyc.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
